// File: rtl/tsip_pkg.sv
// Shared TSIP framing constants and the transmit scheduler state encoding.
package tsip_pkg;

  localparam logic [7:0] c_DLE    = 8'h10;
  localparam logic [7:0] c_ETX    = 8'h03;
  localparam logic [7:0] c_CMD_ID = 8'h8E;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_HDR_WAIT     = 3'd1,
    S_FETCH        = 3'd2,
    S_DATA_WAIT    = 3'd3,
    S_STUFF_WAIT   = 3'd4,
    S_TRL_DLE_WAIT = 3'd5,
    S_TRL_ETX_WAIT = 3'd6
  } state_t;

endpackage

// File: rtl/tsip_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every variable written here is defaulted first so no latch can be inferred.
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(pointer) + i) % N_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/tsip_tx_scheduler.sv
// Round-robin TSIP packet scheduler: frames the granted source's payload
// (DLE header, DLE stuffing, DLE ETX trailer) and paces it on uart_tx done pulses.
module tsip_tx_scheduler #(
  parameter int N_REQ       = 2,
  parameter int IDX_W       = 1,
  parameter int MAX_PAYLOAD = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [N_REQ-1:0]     i_req,
  output logic [N_REQ-1:0]     o_gnt,
  input  logic [8*N_REQ-1:0]   i_req_byte,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [N_REQ-1:0]     i_req_last,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_pkt_done,
  output logic [IDX_W-1:0]     o_pkt_src,
  output logic                 o_err
);

  import tsip_pkg::*;

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] ptr, idx, win;
  logic             found;
  logic [CNT_W-1:0] count;
  logic             cur_last;
  logic             dv_d, start, capture, finish, end_cond;
  logic [7:0]       byte_d, sel_byte;
  logic             sel_valid, sel_last;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (i_req),
    .pointer (ptr),
    .winner  (win),
    .found   (found)
  );

  assign sel_valid   = i_req_valid[idx];
  assign sel_last    = i_req_last[idx];
  assign sel_byte    = i_req_byte[{idx, 3'b000} +: 8];
  assign o_req_ready = (state == S_FETCH) ? o_gnt : '0;
  assign o_busy      = (state != S_IDLE);
  assign end_cond    = cur_last || (count == CNT_W'(MAX_PAYLOAD));

  always_comb begin
    state_d = state;
    dv_d    = 1'b0;
    byte_d  = o_tx_byte;
    start   = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    unique case (state)
      S_IDLE: if (i_enable && found) begin
        start = 1'b1; dv_d = 1'b1; byte_d = c_DLE; state_d = S_HDR_WAIT;
      end
      S_HDR_WAIT: if (i_tx_done) state_d = S_FETCH;
      S_FETCH: if (sel_valid) begin
        capture = 1'b1; dv_d = 1'b1; byte_d = sel_byte; state_d = S_DATA_WAIT;
      end
      // o_tx_byte still holds the payload byte just sent, so it doubles as the stuffing test.
      S_DATA_WAIT: if (i_tx_done) begin
        if (o_tx_byte == c_DLE) begin
          dv_d = 1'b1; byte_d = c_DLE; state_d = S_STUFF_WAIT;
        end else if (end_cond) begin
          dv_d = 1'b1; byte_d = c_DLE; state_d = S_TRL_DLE_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_STUFF_WAIT: if (i_tx_done) begin
        if (end_cond) begin
          dv_d = 1'b1; byte_d = c_DLE; state_d = S_TRL_DLE_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_TRL_DLE_WAIT: if (i_tx_done) begin
        dv_d = 1'b1; byte_d = c_ETX; state_d = S_TRL_ETX_WAIT;
      end
      S_TRL_ETX_WAIT: if (i_tx_done) begin
        finish = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tx_dv    <= 1'b0;
      o_tx_byte  <= c_DLE;
      o_gnt      <= '0;
      ptr        <= '0;
      idx        <= '0;
      count      <= '0;
      cur_last   <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_src  <= '0;
      o_err      <= 1'b0;
    end else begin
      o_tx_dv    <= dv_d;
      o_tx_byte  <= byte_d;
      o_pkt_done <= finish;
      o_err      <= finish & ~cur_last;
      if (start) begin
        o_gnt <= N_REQ'(1) << win;
        idx   <= win;
      end
      if (capture) begin
        cur_last <= sel_last;
        count    <= count + 1'b1;
      end
      if (finish) begin
        o_gnt     <= '0;
        count     <= '0;
        o_pkt_src <= idx;
        if (idx == IDX_W'(N_REQ - 1)) ptr <= '0;
        else                          ptr <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tsip_tx_scheduler.sv
// Scoreboard bench: a packet-level model predicts the framed byte stream and
// completion order; a negedge monitor with a uart_tx model pops and compares.
module tb_tsip_tx_scheduler;
  import tsip_pkg::*;

  localparam int N     = 2;
  localparam int IDX_W = 1;
  localparam int MAXP  = 4;

  typedef struct packed { logic [7:0] b; logic l; } item_t;
  typedef struct packed { logic [IDX_W-1:0] src; logic err; } pkt_t;

  logic             clk = 1'b0;
  logic             rst, enable;
  logic [N-1:0]     req = '0, req_valid = '0, req_last = '0;
  logic [8*N-1:0]   req_byte = '0;
  logic [N-1:0]     gnt, ready;
  logic             tx_dv, busy, pkt_done, err;
  logic [7:0]       tx_byte;
  logic             tx_done = 1'b0;
  logic [IDX_W-1:0] pkt_src;

  always #5 clk = ~clk;

  tsip_tx_scheduler #(.N_REQ(N), .IDX_W(IDX_W), .MAX_PAYLOAD(MAXP)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_req(req), .o_gnt(gnt),
    .i_req_byte(req_byte), .i_req_valid(req_valid), .i_req_last(req_last),
    .o_req_ready(ready), .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .i_tx_done(tx_done),
    .o_busy(busy), .o_pkt_done(pkt_done), .o_pkt_src(pkt_src), .o_err(err)
  );

  int total = 0, bad = 0, proto_err = 0, dv_count = 0;
  int fixed_delay = 20, uart_cnt = 0, model_ptr = 0;
  bit rand_delay = 0, uart_busy = 0;

  item_t      src_q [N][$];
  logic [7:0] pay   [N][$];
  bit         has_last [N];
  logic [7:0] exp_tx [$];
  pkt_t       exp_pkt [$];
  logic [7:0] exp_b;
  pkt_t       exp_p;
  logic [N-1:0] active = '0, hs_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Source models: request while holding a packet, drop request at grant, random valid stalls.
  always @(posedge clk) hs_mask <= req_valid & ready;

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        src_q[k].delete();
        active[k] = 1'b0;
      end else begin
        if (hs_mask[k] && src_q[k].size() > 0) src_q[k].delete(0);
        if (gnt[k]) active[k] = 1'b1;
        else if (active[k]) begin
          active[k] = 1'b0;
          src_q[k].delete();
        end
      end
      req[k] = !rst && !active[k] && (src_q[k].size() > 0);
      if (gnt[k] && src_q[k].size() > 0 && $urandom_range(0, 3) != 0) begin
        req_valid[k]       = 1'b1;
        req_byte[8*k +: 8] = src_q[k][0].b;
        req_last[k]        = src_q[k][0].l;
      end else begin
        req_valid[k]       = 1'b0;
        req_byte[8*k +: 8] = 8'($urandom);
        req_last[k]        = 1'($urandom);
      end
    end
  end

  // uart_tx model plus output monitor.
  always @(negedge clk) begin
    if (rst) begin
      exp_tx.delete();
      exp_pkt.delete();
    end
    if (tx_done) begin
      tx_done   = 1'b0;
      uart_busy = 1'b0;
    end else if (uart_busy) begin
      if (uart_cnt <= 1) tx_done = 1'b1;
      else uart_cnt--;
    end
    if (!rst) begin
      if ((ready & ~gnt) != '0 || $countones(gnt) > 1 || (err && !pkt_done)) begin
        proto_err++;
        if (proto_err < 5) $display("FAIL handshake: gnt=%b ready=%b err=%b", gnt, ready, err);
      end
      if (tx_dv) begin
        dv_count++;
        if (uart_busy) begin
          proto_err++;
          $display("FAIL tx_dv_while_busy: byte %0h", tx_byte);
        end
        uart_busy = 1'b1;
        uart_cnt  = rand_delay ? int'($urandom_range(1, 20)) : fixed_delay;
        if (exp_tx.size() == 0) check("tx_unexpected", {24'h0, tx_byte}, 32'hFFFF_FFFF);
        else begin
          exp_b = exp_tx.pop_front();
          check("tx_byte", {24'h0, tx_byte}, {24'h0, exp_b});
        end
      end
      if (pkt_done) begin
        if (exp_pkt.size() == 0) check("pkt_unexpected", 32'd1, 32'd0);
        else begin
          exp_p = exp_pkt.pop_front();
          check("pkt_src", 32'(pkt_src), 32'(exp_p.src));
          check("pkt_err", 32'(err), 32'(exp_p.err));
        end
      end
    end
  end

  // Reference: framed stream is DLE, payload (each DLE doubled) up to last or MAXP bytes, DLE ETX.
  task automatic expect_pkt(input int k);
    exp_tx.push_back(c_DLE);
    for (int j = 0; j < pay[k].size() && j < MAXP; j++) begin
      exp_tx.push_back(pay[k][j]);
      if (pay[k][j] == c_DLE) exp_tx.push_back(c_DLE);
    end
    exp_tx.push_back(c_DLE);
    exp_tx.push_back(c_ETX);
    exp_pkt.push_back('{src: IDX_W'(k), err: !(has_last[k] && pay[k].size() <= MAXP)});
  endtask

  task automatic submit(input logic [N-1:0] mask);
    logic [N-1:0] pending = mask;
    for (int k = 0; k < N; k++)
      if (mask[k])
        for (int j = 0; j < pay[k].size(); j++)
          src_q[k].push_back('{b: pay[k][j], l: has_last[k] && (j == pay[k].size() - 1)});
    while (pending != '0) begin
      for (int i = 0; i < N; i++) begin
        int c = (model_ptr + i) % N;
        if (pending[c]) begin
          expect_pkt(c);
          pending[c] = 1'b0;
          model_ptr  = (c + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic gen(input int k, input bit overlong);
    int len = overlong ? MAXP + 2 : int'($urandom_range(1, MAXP));
    pay[k].delete();
    for (int j = 0; j < len; j++) begin
      logic [7:0] b = ($urandom_range(0, 3) == 0) ? c_DLE : 8'($urandom);
      if (j == 0 && $urandom_range(0, 1) == 1) b = c_CMD_ID;
      pay[k].push_back(b);
    end
    has_last[k] = !overlong;
  endtask

  task automatic set_pay(input int k, input logic [31:0] bytes, input int len);
    pay[k].delete();
    for (int j = len - 1; j >= 0; j--) pay[k].push_back(bytes[8*j +: 8]);
    has_last[k] = 1'b1;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (c < 4000 && (exp_tx.size() != 0 || exp_pkt.size() != 0 || busy || req != '0)) begin
      @(posedge clk);
      c++;
    end
    if (c >= 4000) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      exp_tx.delete();
      exp_pkt.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_dv(input int n);
    int c = 0;
    while (dv_count < n && c < 3000) begin
      @(posedge clk);
      c++;
    end
    if (c >= 3000) check("dv_wait_timeout", 32'd1, 32'd0);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_gnt"},      32'(gnt),      32'd0);
    check({tag, "_ready"},    32'(ready),    32'd0);
    check({tag, "_tx_dv"},    32'(tx_dv),    32'd0);
    check({tag, "_tx_byte"},  32'(tx_byte),  32'h10);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
    check({tag, "_pkt_src"},  32'(pkt_src),  32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_checks("por");
    rst = 1'b0;
    @(posedge clk); #1;

    set_pay(0, 32'h008E_A201, 3); submit(2'b01); drain("req0_basic");
    set_pay(1, 32'h008E_10A5, 3); submit(2'b10); drain("req1_stuff");

    gen(0, 0); gen(1, 0); submit(2'b11); drain("both_a");
    gen(0, 0); submit(2'b01); drain("single");
    gen(0, 0); gen(1, 0); submit(2'b11); drain("both_b");

    enable = 1'b0;
    set_pay(0, 32'h8E10_2233, 4); submit(2'b01);
    base = dv_count;
    repeat (100) @(posedge clk);
    #1 check("disabled_no_dv", 32'(dv_count - base), 32'd0);
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1;
    check("enable_lat_dv", 32'(tx_dv), 32'd1);
    check("enable_lat_byte", 32'(tx_byte), 32'h10);
    wait_dv(base + 3);
    enable = 1'b0;
    drain("enable_drop");
    enable = 1'b1;

    rand_delay = 1'b1;
    gen(1, 1); submit(2'b10); drain("overlong");
    rand_delay = 1'b0;

    set_pay(0, 32'h8E11_2233, 4); submit(2'b01);
    base = dv_count;
    wait_dv(base + 2);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 reset_checks("mid_rst");
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
    @(posedge clk); #1;
    set_pay(0, 32'h008E_4455, 3); submit(2'b01); drain("after_reset");

    rand_delay = 1'b1;
    for (int t = 0; t < 30; t++) begin
      logic [N-1:0] mask = N'($urandom_range(1, 3));
      for (int k = 0; k < N; k++)
        if (mask[k]) gen(k, $urandom_range(0, 4) == 0);
      submit(mask);
      drain("random");
    end

    check("leftover_tx", 32'(exp_tx.size()), 32'd0);
    check("leftover_pkt", 32'(exp_pkt.size()), 32'd0);
    check("protocol", 32'(proto_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tsip_tx_scheduler.md
Name: tsip_tx_scheduler

Overview:
Shares the single TSIP UART transmitter between several packet sources, for example the Thunderbolt config sequencer and a host query path.
- Arbitrates between sources round-robin.
- Streams the granted source's raw payload to the transmitter.
- Adds TSIP framing: leading DLE, DLE stuffing, trailing DLE ETX.
- Paces transmission byte-by-byte on the transmitter's done pulse.
It sits between the packet sources and the uart_tx instance inside the Thunderbolt interface.

Parameters:
N_REQ, 2, number of requesters (2..8)
IDX_W, 1, width of source index, equal to clog2(N_REQ) with a minimum of 1
MAX_PAYLOAD, 32, maximum unstuffed payload bytes per packet before forced termination

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_enable  in  1  1 = new packets may start; a packet already in progress always completes
i_req  in  N_REQ  per-source packet request; level, held until granted
o_gnt  out  N_REQ  one-hot grant, held from packet start to packet end
i_req_byte  in  8*N_REQ  flattened payload byte per source; source k occupies [8k+7:8k]
i_req_valid  in  N_REQ  payload byte valid per source
i_req_last  in  N_REQ  marks the final payload byte
o_req_ready  out  N_REQ  byte accepted when valid&ready; only the granted bit can be 1
o_tx_dv  out  1  one-cycle start pulse to uart_tx
o_tx_byte  out  8  byte to uart_tx, held stable until the next o_tx_dv
i_tx_done  in  1  uart_tx byte-complete pulse
o_busy  out  1  high while any state other than IDLE is active
o_pkt_done  out  1  one-cycle pulse after ETX completes
o_pkt_src  out  IDX_W  index of the last completed source, valid with o_pkt_done
o_err  out  1  one-cycle pulse with o_pkt_done when the packet was force-terminated

Behaviour:
- Reset (asynchronous, any time, including mid-packet):
  - All outputs 0; o_tx_byte = 8'h10.
  - State = IDLE; round-robin pointer = 0; payload count = 0.
  - A byte already shifting in uart_tx is not recalled; the scheduler simply restarts.
- States and transitions:
  - IDLE: if i_enable and |i_req, pick a winner round-robin. Search starts at pointer, then pointer+1, and so on, wrapping modulo N_REQ. Next edge: o_gnt = onehot(winner), o_tx_byte = DLE, o_tx_dv = 1 for one cycle, go to HDR_WAIT.
  - HDR_WAIT: on i_tx_done, go to FETCH.
  - FETCH: o_req_ready[gnt] = 1 combinationally. On valid:
    - Capture the byte and the last flag and increment the count.
    - Drive o_tx_byte and pulse o_tx_dv on the next edge.
    - Go to DATA_WAIT.
  - DATA_WAIT: on i_tx_done:
    - byte == 8'h10 and not yet stuffed → pulse o_tx_dv again with DLE, go to STUFF_WAIT.
    - else if last, or count == MAX_PAYLOAD → send DLE, go to TRL_DLE_WAIT.
    - else → FETCH.
  - STUFF_WAIT: on i_tx_done, apply the same last/count check as DATA_WAIT → TRL_DLE_WAIT or FETCH.
  - TRL_DLE_WAIT: on i_tx_done, send ETX (8'h03), go to TRL_ETX_WAIT.
  - TRL_ETX_WAIT: on i_tx_done:
    - Pulse o_pkt_done and set o_pkt_src.
    - Pulse o_err if terminated by count without last.
    - Clear o_gnt; pointer = winner+1 mod N_REQ; count = 0.
    - Go to IDLE.
- Transmit and handshake rules:
  - Exactly one o_tx_dv per transmitted byte.
  - o_tx_dv is never asserted while waiting for i_tx_done.
  - i_tx_done is ignored in IDLE and FETCH.
  - Stuffed DLEs do not count toward MAX_PAYLOAD.
  - Payload bytes are never stuffed except the single extra DLE after a payload 8'h10.
- Boundary conditions:
  - Requester drops i_req mid-packet: ignored; the grant holds until the trailer completes.
  - i_enable falling mid-packet: no effect on the packet in progress.
  - Simultaneous requests: only one grant per packet; the losers keep requesting.
  - Source slow to present valid: FETCH waits indefinitely; no timeout.
- Latency: from a request in IDLE to the first o_tx_dv is 1 cycle. The minimum gap between o_tx_done and the next o_tx_dv is 1 cycle, 2 when passing through FETCH.

Decomposition:
- Shared package tsip_pkg: c_DLE = 8'h10, c_ETX = 8'h03, c_CMD_ID = 8'h8E, and the scheduler state encoding localparams.
- One sub-module, rr_arbiter: parameter N_REQ; inputs req and pointer; outputs winner index and a found flag. Purely combinational.

Test Plan:
- req0 streams 8E A2 01 (last on 01), with a uart_tx model giving done 20 cycles after dv:
  - tx sequence 10 8E A2 01 10 03;
  - o_pkt_done with o_pkt_src = 0; o_err = 0.
- req1 streams 8E 10 A5 (last):
  - tx sequence 10 8E 10 10 A5 10 03;
  - count = 3.
- req0 and req1 both asserted from reset:
  - req0's packet is sent first, then req1's;
  - a second simultaneous round grants req1 first.
- i_enable = 0 with req0 high: no o_tx_dv for 100 cycles.
  - Raise enable → 1 cycle later o_tx_dv with 10.
  - Drop enable mid-payload → the packet still ends 10 03.
- MAX_PAYLOAD = 4, source sends 6 bytes with no last:
  - tx shows 4 payload bytes then 10 03;
  - o_err = 1 with o_pkt_done.
- Assert i_rst during DATA_WAIT:
  - all outputs 0 immediately, without waiting for a clock edge;
  - after release, a new req0 packet starts cleanly with the header 10.
